if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, issues requests to instruction memory over a ready-based handshake, and drives the IF/ID pipeline register that the decode stage and the hazard detection unit read. It obeys the hazard unit's stall (load-use) and flush (taken branch or jump) outputs. It tolerates multi-cycle instruction memory by holding the address stable, inserting bubbles, and discarding fetches made stale by a redirect.

---
 rtl/mips_pkg.sv | 15 +
 rtl/if_id_reg.sv | 62 ++++++
 rtl/if_stage.sv | 148 ++++++++++++++
 tb/tb_if_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath width, NOP encoding
// and the instruction-fetch state encoding.
package mips_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between two stages with clear-to-bubble, hold and load
// controls; clear has priority over hold, hold over load.
module if_id_reg
   import mips_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            hold,
   input  logic            load,
   input  logic            d_valid,
   input  logic [XLEN-1:0] d_instr,
   input  logic [XLEN-1:0] d_pc4,
   output logic            q_valid,
   output logic [XLEN-1:0] q_instr,
   output logic [XLEN-1:0] q_pc4
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc4_q,   pc4_d;

   // NOTE: every output of an always_comb gets a default first, so no path
   // through the if/else chain can leave a variable unassigned and infer a latch.
   always_comb begin
      valid_d = 1'b0;
      instr_d = NOP;
      pc4_d   = '0;
      if (clear) begin
         valid_d = 1'b0;
         instr_d = NOP;
         pc4_d   = '0;
      end else if (hold) begin
         valid_d = valid_q;
         instr_d = instr_q;
         pc4_d   = pc4_q;
      end else if (load) begin
         valid_d = d_valid;
         instr_d = d_instr;
         pc4_d   = d_pc4;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         instr_q <= NOP;
         pc4_q   <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
      end
   end

   assign q_valid = valid_q;
   assign q_instr = instr_q;
   assign q_pc4   = pc4_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, ready-based imem handshake, stall/flush
// handling with a one-word hold buffer and stale-request discard.
module if_stage
   import mips_pkg::*;
#(
   parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_instr,
   output logic [XLEN-1:0] if_id_pc4
);

   fetch_state_e    state_q,     state_d;
   logic [XLEN-1:0] pc_q,        pc_d;
   logic [XLEN-1:0] buf_pc4_q,   buf_pc4_d;
   logic [XLEN-1:0] buf_instr_q, buf_instr_d;
   logic [XLEN-1:0] pending_q,   pending_d;
   logic            req_q,       req_d;

   logic            ifid_clear, ifid_hold, ifid_load;
   logic [XLEN-1:0] ifid_instr, ifid_pc4;
   logic [XLEN-1:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      buf_pc4_d   = buf_pc4_q;
      buf_instr_d = buf_instr_q;
      pending_d   = pending_q;
      ifid_clear  = 1'b0;
      ifid_hold   = 1'b0;
      ifid_load   = 1'b0;
      ifid_instr  = imem_rdata;
      ifid_pc4    = pc_plus4;

      unique case (state_q)
         FETCH: begin
            if (imem_ready) begin
               if (flush) begin
                  pc_d       = redirect_pc;
                  ifid_clear = 1'b1;
               end else if (stall) begin
                  buf_pc4_d   = pc_plus4;
                  buf_instr_d = imem_rdata;
                  ifid_hold   = 1'b1;
                  state_d     = HOLD;
               end else begin
                  pc_d      = pc_plus4;
                  ifid_load = 1'b1;
               end
            end else begin
               // pc stays put on a redirect so the outstanding address is stable
               if (flush) begin
                  pending_d  = redirect_pc;
                  ifid_clear = 1'b1;
                  state_d    = DISCARD;
               end else if (stall) begin
                  ifid_hold = 1'b1;
               end else begin
                  ifid_clear = 1'b1;
               end
            end
         end

         HOLD: begin
            if (flush) begin
               pc_d       = redirect_pc;
               ifid_clear = 1'b1;
               state_d    = FETCH;
            end else if (stall) begin
               ifid_hold = 1'b1;
            end else begin
               pc_d       = buf_pc4_q;
               ifid_instr = buf_instr_q;
               ifid_pc4   = buf_pc4_q;
               ifid_load  = 1'b1;
               state_d    = FETCH;
            end
         end

         DISCARD: begin
            if (flush) pending_d = redirect_pc;
            if (stall) ifid_hold  = 1'b1;
            else       ifid_clear = 1'b1;
            if (imem_ready) begin
               pc_d    = flush ? redirect_pc : pending_q;
               state_d = FETCH;
            end
         end

         default: begin
            state_d    = FETCH;
            ifid_clear = 1'b1;
         end
      endcase

      req_d = (state_d != HOLD);
   end

   // NOTE: buffer and pending words are plain registers, not a memory array,
   // so they are reset along with the rest of the stage state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FETCH;
         pc_q        <= PC_RESET;
         buf_pc4_q   <= '0;
         buf_instr_q <= NOP;
         pending_q   <= '0;
         req_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         buf_pc4_q   <= buf_pc4_d;
         buf_instr_q <= buf_instr_d;
         pending_q   <= pending_d;
         req_q       <= req_d;
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_q;

   if_id_reg u_if_id_reg (
      .clk     (clk),
      .rst     (rst),
      .clear   (ifid_clear),
      .hold    (ifid_hold),
      .load    (ifid_load),
      .d_valid (1'b1),
      .d_instr (ifid_instr),
      .d_pc4   (ifid_pc4),
      .q_valid (if_id_valid),
      .q_instr (if_id_instr),
      .q_pc4   (if_id_pc4)
   );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random traffic, checked each
// cycle against a flag-based behavioural model of the fetch rules.
module tb_if_stage;

   localparam logic [31:0] TB_PC_RESET = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, imem_ready;
   logic [31:0] redirect_pc, imem_rdata;
   logic        imem_req, if_id_valid;
   logic [31:0] imem_addr, if_id_instr, if_id_pc4;

   int tests = 0;
   int fails = 0;

   // model state: pc, buffered-word flag, stale-request flag, IF/ID contents
   logic [31:0] m_pc, m_word, m_target, m_i, m_p4;
   bit          m_held, m_stale, m_v;

   always #5 clk = ~clk;

   if_stage #(.PC_RESET(TB_PC_RESET)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .if_id_valid (if_id_valid),
      .if_id_instr (if_id_instr),
      .if_id_pc4   (if_id_pc4)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_pc = TB_PC_RESET; m_held = 0; m_stale = 0; m_word = '0; m_target = '0;
      m_v = 0; m_i = '0; m_p4 = '0;
   endtask

   task automatic m_bubble();
      m_v = 0; m_i = 32'h0; m_p4 = 32'h0;
   endtask

   task automatic m_update(input bit s, input bit f, input logic [31:0] r, input bit rdy);
      if (m_held) begin
         if (f) begin
            m_pc = r; m_held = 0; m_bubble();
         end else if (!s) begin
            m_v = 1; m_i = m_word; m_p4 = m_pc + 4; m_pc = m_pc + 4; m_held = 0;
         end
      end else if (m_stale) begin
         if (f) m_target = r;
         if (!s) m_bubble();
         if (rdy) begin
            m_pc = m_target; m_stale = 0;
         end
      end else if (rdy) begin
         if (f) begin
            m_pc = r; m_bubble();
         end else if (s) begin
            m_held = 1; m_word = mem_word(m_pc);
         end else begin
            m_v = 1; m_i = mem_word(m_pc); m_p4 = m_pc + 4; m_pc = m_pc + 4;
         end
      end else begin
         if (f) begin
            m_stale = 1; m_target = r; m_bubble();
         end else if (!s) begin
            m_bubble();
         end
      end
   endtask

   task automatic check_outputs();
      check("imem_req",    32'(imem_req),    32'(!m_held));
      check("imem_addr",   imem_addr,        m_pc);
      check("if_id_valid", 32'(if_id_valid), 32'(m_v));
      check("if_id_instr", if_id_instr,      m_i);
      check("if_id_pc4",   if_id_pc4,        m_p4);
   endtask

   // Runs at posedge+1: check this cycle's outputs, drive inputs, advance.
   task automatic step(input bit s, input bit f, input logic [31:0] r, input bit rdy);
      check_outputs();
      stall = s; flush = f; redirect_pc = r; imem_ready = rdy;
      imem_rdata = mem_word(m_pc);
      @(posedge clk);
      m_update(s, f, r, rdy);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 0; flush = 0; redirect_pc = '0; imem_ready = 0; imem_rdata = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // zero-wait memory; reset PC wraps to 0 on the second fetch
      check("reset_addr", imem_addr, TB_PC_RESET);
      step(0, 0, 0, 1);
      check("wrap_addr", imem_addr, 32'h0);
      check("wrap_pc4", if_id_pc4, 32'h0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

      // ready three cycles late, twice
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
         step(0, 0, 0, 1);
      end

      // two-cycle stall with ready, then release
      step(0, 0, 0, 1);
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      check("hold_req", 32'(imem_req), 32'h0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      // flush during wait, second flush wins, stale word dropped
      step(0, 1, 32'h40, 0);
      step(0, 1, 32'h80, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      check("discard_addr", imem_addr, 32'h80);
      step(0, 0, 0, 1);

      // flush and stall together in HOLD
      step(1, 0, 0, 1);
      step(1, 1, 32'h100, 1);
      check("hold_flush_addr", imem_addr, 32'h100);
      check("hold_flush_valid", 32'(if_id_valid), 32'h0);
      step(0, 0, 0, 1);

      // async reset mid-wait with a valid word held in IF/ID
      step(0, 0, 0, 1);
      step(1, 0, 0, 0);
      check_outputs();
      rst = 1'b1;
      #1;
      check("arst_addr",  imem_addr, TB_PC_RESET);
      check("arst_req",   32'(imem_req), 32'h1);
      check("arst_valid", 32'(if_id_valid), 32'h0);
      check("arst_instr", if_id_instr, 32'h0);
      check("arst_pc4",   if_id_pc4, 32'h0);
      stall = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      m_reset();
      step(0, 0, 0, 1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 25,
              $urandom_range(0, 99) < 12,
              {$urandom_range(0, 255), 2'b00} << 2,
              $urandom_range(0, 99) < 60);
      end
      check_outputs();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
